// File: rtl/rom_loader.sv
// rom_loader: boot loader that assembles {opcode,data} words from a host byte stream,
// writes them to instruction memory and gates the core. Define ROM_LOADER_CHECKSUM_EN for a trailing checksum byte.
module rom_loader #(
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int IW    = 12
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic [7:0]    byte_i,
    input  logic          byte_valid_i,
    output logic          byte_ready_o,
    output logic          wr_en_o,
    output logic [AW-1:0] wr_addr_o,
    output logic [IW-1:0] wr_data_o,
    output logic          cpu_run_o,
    output logic          done_o,
    output logic          err_o
);

    // state  | meaning
    // S_IDLE | waiting for start after reset
    // S_HDR  | expecting header byte (word count)
    // S_OPC  | expecting opcode byte of next word
    // S_DAT  | expecting data byte of current word
    // S_CHK  | expecting checksum byte (checksum build only)
    // S_RUN  | image accepted, core running
    // S_FAIL | session rejected
    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_OPC,
        S_DAT,
        S_RUN,
        S_FAIL
`ifdef ROM_LOADER_CHECKSUM_EN
        , S_CHK
`endif
    } state_t;

    state_t        state_q;
    logic          ready_q;
    logic          wr_en_q;
    logic [AW-1:0] wr_addr_q;
    logic [IW-1:0] wr_data_q;
    logic          cpu_run_q;
    logic          done_q;
    logic          err_q;
    logic [AW:0]   n_q;
    logic [AW:0]   idx_q;
    logic [3:0]    opc_q;

    logic accept;
    logic hdr_bad;
    logic last_word;

    assign accept    = byte_valid_i & ready_q;
    assign hdr_bad   = (byte_i == 8'd0) || (int'(byte_i) > DEPTH);
    // index is one bit wider than the address so a full-depth image terminates without wrapping
    assign last_word = (idx_q + (AW+1)'(1)) == n_q;

`ifdef ROM_LOADER_CHECKSUM_EN
    logic [7:0] sum_q;
    logic [7:0] sum_d;
    assign sum_d = sum_q + byte_i;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            ready_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            cpu_run_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            n_q       <= '0;
            idx_q     <= '0;
            opc_q     <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
            sum_q     <= '0;
`endif
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q <= S_HDR;
                        ready_q <= 1'b1;
                    end
                end
                S_HDR: begin
                    if (accept) begin
                        if (hdr_bad) begin
                            state_q <= S_FAIL;
                            ready_q <= 1'b0;
                            err_q   <= 1'b1;
                        end else begin
                            n_q     <= byte_i[AW:0];
                            idx_q   <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
                            sum_q   <= byte_i;
`endif
                            state_q <= S_OPC;
                        end
                    end
                end
                S_OPC: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        opc_q   <= byte_i[3:0];
`ifdef ROM_LOADER_CHECKSUM_EN
                        sum_q   <= sum_d;
`endif
                        state_q <= S_DAT;
                    end
                end
                S_DAT: begin
                    if (accept) begin
                        ready_q   <= 1'b0;
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= idx_q[AW-1:0];
                        wr_data_q <= {opc_q, byte_i};
                        idx_q     <= idx_q + (AW+1)'(1);
`ifdef ROM_LOADER_CHECKSUM_EN
                        sum_q     <= sum_d;
`endif
                        if (last_word) begin
`ifdef ROM_LOADER_CHECKSUM_EN
                            state_q   <= S_CHK;
`else
                            state_q   <= S_RUN;
                            cpu_run_q <= 1'b1;
                            done_q    <= 1'b1;
`endif
                        end else begin
                            state_q <= S_OPC;
                        end
                    end
                end
`ifdef ROM_LOADER_CHECKSUM_EN
                S_CHK: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        ready_q <= 1'b0;
                        if (sum_d == 8'd0) begin
                            state_q   <= S_RUN;
                            cpu_run_q <= 1'b1;
                            done_q    <= 1'b1;
                        end else begin
                            state_q <= S_FAIL;
                            err_q   <= 1'b1;
                        end
                    end
                end
`endif
                S_RUN, S_FAIL: begin
                    if (start_i) begin
                        state_q   <= S_HDR;
                        ready_q   <= 1'b1;
                        cpu_run_q <= 1'b0;
                        done_q    <= 1'b0;
                        err_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign byte_ready_o = ready_q;
    assign wr_en_o      = wr_en_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;
    assign cpu_run_o    = cpu_run_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: randomized image loads checked against a stream-level model of the loader
// (word list, checksum rule, memory image, write/run timing). Honors ROM_LOADER_CHECKSUM_EN.
module tb_rom_loader;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int IW    = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          bvalid;
    logic [7:0]    bin;
    logic          ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [IW-1:0] wr_data;
    logic          cpu_run;
    logic          done;
    logic          err;

    rom_loader #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .byte_i      (bin),
        .byte_valid_i(bvalid),
        .byte_ready_o(ready),
        .wr_en_o     (wr_en),
        .wr_addr_o   (wr_addr),
        .wr_data_o   (wr_data),
        .cpu_run_o   (cpu_run),
        .done_o      (done),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    logic [IW-1:0] act_mem [DEPTH];
    logic [IW-1:0] exp_mem [DEPTH];
    bit            exp_known [DEPTH];
    int            mon_addr [$];
    logic [IW-1:0] mon_data [$];
    int            mon_cyc [$];
    int            run_rise_cyc = -1;
    logic          run_prev = 1'b0;
    int            ready_viol = 0;

    // instruction memory stand-in plus write/run-edge recorder
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            act_mem[wr_addr] <= wr_data;
            mon_addr.push_back(int'(wr_addr));
            mon_data.push_back(wr_data);
            mon_cyc.push_back(cyc);
            if (ready !== 1'b0) ready_viol <= ready_viol + 1;
        end
        if (cpu_run === 1'b1 && run_prev !== 1'b1) run_rise_cyc <= cyc;
        run_prev <= cpu_run;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] calc_chk(input logic [7:0] hdr, input logic [7:0] pl[$]);
        logic [7:0] s;
        s = hdr;
        foreach (pl[i]) s = s + pl[i];
        return 8'h00 - s;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // returns with the bench at the negedge right after the accepting edge
    task automatic send_byte(input logic [7:0] b, input int maxgap, output int acc_cyc);
        int g;
        int t;
        g = $urandom_range(maxgap, 0);
        bvalid = 1'b0;
        repeat (g) @(negedge clk);
        bvalid = 1'b1;
        bin = b;
        t = 0;
        while (ready !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (t >= 40) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout got ready=%b want 1", ready);
        end
        @(negedge clk);
        acc_cyc = cyc;
        bvalid = 1'b0;
        bin = 8'($urandom);
    endtask

    task automatic load_and_check(input string name, input logic [7:0] hdr, input logic [7:0] pl[$],
                                  input logic [7:0] chk, input int gap, input bit poke);
        int n;
        bit bad;
        bit ok;
        logic [7:0] s;
        int base;
        int vbase;
        int acc;
        int fin;
        int dcyc [$];
        logic [IW-1:0] ew [$];
        n = int'(hdr);
        bad = (n == 0) || (n > DEPTH);
        s = hdr;
        if (!bad) begin
            for (int i = 0; i < n; i++) begin
                ew.push_back({pl[2*i][3:0], pl[2*i+1]});
                s = s + pl[2*i] + pl[2*i+1];
            end
        end
`ifdef ROM_LOADER_CHECKSUM_EN
        s = s + chk;
        ok = !bad && (s == 8'h00);
`else
        ok = !bad && (s == s);
`endif
        pulse_start();
        vectors++;
        if (ready !== 1'b1) begin miscompares++; $display("FAIL %s.start_ready got %b want 1", name, ready); end
        vectors++;
        if ({cpu_run, done, err} !== 3'b000) begin
            miscompares++;
            $display("FAIL %s.start_clear got run/done/err=%b want 000", name, {cpu_run, done, err});
        end
        base = mon_addr.size();
        vbase = ready_viol;
        send_byte(hdr, gap, acc);
        fin = acc;
        if (!bad) begin
            for (int i = 0; i < n; i++) begin
                send_byte(pl[2*i], gap, acc);
                if (poke && i == 0) pulse_start();
                send_byte(pl[2*i+1], gap, acc);
                dcyc.push_back(acc);
            end
            fin = acc;
`ifdef ROM_LOADER_CHECKSUM_EN
            send_byte(chk, gap, acc);
            fin = acc;
`endif
        end
        vectors++;
        if (cpu_run !== ok) begin miscompares++; $display("FAIL %s.cpu_run got %b want %b", name, cpu_run, ok); end
        vectors++;
        if (done !== ok) begin miscompares++; $display("FAIL %s.done got %b want %b", name, done, ok); end
        vectors++;
        if (err !== !ok) begin miscompares++; $display("FAIL %s.err got %b want %b", name, err, !ok); end
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (mon_addr.size() - base != ew.size()) begin
            miscompares++;
            $display("FAIL %s.write_count got %0d want %0d", name, mon_addr.size() - base, ew.size());
        end else begin
            for (int i = 0; i < ew.size(); i++) begin
                vectors++;
                if (mon_addr[base+i] != i || mon_data[base+i] !== ew[i] || mon_cyc[base+i] != dcyc[i]) begin
                    miscompares++;
                    $display("FAIL %s.write%0d got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d", name, i,
                             mon_addr[base+i], mon_data[base+i], mon_cyc[base+i], i, ew[i], dcyc[i]);
                end
            end
        end
        if (ok) begin
            vectors++;
            if (run_rise_cyc != fin) begin
                miscompares++;
                $display("FAIL %s.run_rise got cyc %0d want %0d", name, run_rise_cyc, fin);
            end
        end
        vectors++;
        if (ready_viol != vbase) begin
            miscompares++;
            $display("FAIL %s.ready_in_write got %0d want %0d", name, ready_viol - vbase, 0);
        end
        for (int i = 0; i < ew.size(); i++) begin
            exp_mem[i] = ew[i];
            exp_known[i] = 1'b1;
        end
        for (int a = 0; a < DEPTH; a++) begin
            if (exp_known[a]) begin
                vectors++;
                if (act_mem[a] !== exp_mem[a]) begin
                    miscompares++;
                    $display("FAIL %s.mem%0d got %h want %h", name, a, act_mem[a], exp_mem[a]);
                end
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        vectors++;
        if ({ready, wr_en, wr_addr, wr_data, cpu_run, done, err} !== '0) begin
            miscompares++;
            $display("FAIL %s got rdy=%b we=%b a=%h d=%h run=%b done=%b err=%b want all 0", name,
                     ready, wr_en, wr_addr, wr_data, cpu_run, done, err);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        bvalid = 1'b0;
        bin = 8'h00;
        repeat (3) @(negedge clk);
        check_all_zero("reset_hold");
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset_idle");
    endtask

    task automatic test_idle_start_valid();
        start = 1'b1;
        bvalid = 1'b1;
        bin = 8'h00;
        @(negedge clk);
        start = 1'b0;
        bvalid = 1'b0;
        vectors++;
        if (ready !== 1'b1) begin miscompares++; $display("FAIL idle_start.ready got %b want 1", ready); end
        @(negedge clk);
        vectors++;
        if (err !== 1'b0) begin miscompares++; $display("FAIL idle_start.byte_taken got err=%b want 0", err); end
    endtask

    task automatic test_spec_image();
        logic [7:0] pl [$];
        pl = {8'h05, 8'hA1, 8'h0C, 8'h3F};
        load_and_check("spec", 8'h02, pl, 8'h0D, 0, 1'b0);
        vectors++;
        if (act_mem[0] !== 12'h5A1) begin miscompares++; $display("FAIL spec.word0 got %h want 5a1", act_mem[0]); end
        vectors++;
        if (act_mem[1] !== 12'hC3F) begin miscompares++; $display("FAIL spec.word1 got %h want c3f", act_mem[1]); end
    endtask

    task automatic test_bad_header();
        logic [7:0] pl [$];
        load_and_check("hdr00", 8'h00, pl, 8'h00, 1, 1'b0);
        load_and_check("hdr21", 8'h21, pl, 8'h00, 1, 1'b0);
        load_and_check("hdr_rand", 8'($urandom_range(255, 33)), pl, 8'h00, 1, 1'b0);
    endtask

    task automatic test_checksum();
        logic [7:0] pl [$];
        pl = {8'h01, 8'h10};
        load_and_check("chk_bad", 8'h01, pl, 8'h00, 0, 1'b0);
        load_and_check("chk_good", 8'h01, pl, 8'hEE, 0, 1'b0);
    endtask

    task automatic test_full_depth();
        logic [7:0] pl [$];
        for (int i = 0; i < 2 * DEPTH; i++) pl.push_back(8'($urandom));
        load_and_check("full", 8'(DEPTH), pl, calc_chk(8'(DEPTH), pl), 3, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] pl [$];
        logic [7:0] hdr;
        logic [7:0] chk;
        for (int k = 0; k < 8; k++) begin
            pl = {};
            hdr = 8'($urandom_range(DEPTH, 1));
            for (int i = 0; i < 2 * int'(hdr); i++) pl.push_back(8'($urandom));
            chk = calc_chk(hdr, pl);
            if ($urandom_range(3, 0) == 0) chk = chk ^ 8'h01;
            load_and_check("random", hdr, pl, chk, $urandom_range(2, 0), 1'($urandom_range(1, 0)));
        end
    endtask

    task automatic test_reset_mid();
        int acc;
        int base;
        logic [7:0] b [8];
        pulse_start();
        base = mon_addr.size();
        send_byte(8'h05, 1, acc);
        for (int i = 0; i < 7; i++) begin
            b[i] = 8'($urandom);
            send_byte(b[i], 1, acc);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_async");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("reset_mid_idle");
        vectors++;
        if (mon_addr.size() - base != 3) begin
            miscompares++;
            $display("FAIL reset_mid.write_count got %0d want 3", mon_addr.size() - base);
        end
        for (int i = 0; i < 3; i++) begin
            exp_mem[i] = {b[2*i][3:0], b[2*i+1]};
            exp_known[i] = 1'b1;
        end
        for (int a = 0; a < DEPTH; a++) begin
            if (exp_known[a]) begin
                vectors++;
                if (act_mem[a] !== exp_mem[a]) begin
                    miscompares++;
                    $display("FAIL reset_mid.mem%0d got %h want %h", a, act_mem[a], exp_mem[a]);
                end
            end
        end
    endtask

    task automatic test_run_restart();
        logic [7:0] pl [$];
        for (int i = 0; i < 6; i++) pl.push_back(8'($urandom));
        load_and_check("run1", 8'h03, pl, calc_chk(8'h03, pl), 0, 1'b0);
        pl = {};
        for (int i = 0; i < 4; i++) pl.push_back(8'($urandom));
        load_and_check("run_restart", 8'h02, pl, calc_chk(8'h02, pl), 0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({cpu_run, done} !== 2'b00) begin
            miscompares++;
            $display("FAIL run_reset got run/done=%b want 00", {cpu_run, done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        for (int a = 0; a < DEPTH; a++) exp_known[a] = 1'b0;
        test_reset();
        test_idle_start_valid();
        test_spec_image();
        test_bad_header();
`ifdef ROM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_full_depth();
        test_random();
        test_reset_mid();
        test_run_restart();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rom_loader.md
# rom_loader

Boot-time instruction loader for the RISC-Y processor. It accepts a byte stream from a host over a valid/ready handshake and assembles 12-bit instruction words: a 4-bit opcode plus 8 bits of immediate data. It writes each word into the 32-entry instruction memory and holds the processor out of execution until the image is complete and valid. It sits directly upstream of the instruction memory and program counter, and drives their write port and the core run-enable.

## Interface
- `DEPTH`, default 32: number of instruction words; must equal 2^`AW`.
- `AW`, default 5: instruction address width, matching the PC width.
- `IW`, default 12: instruction width, {opcode[3:0], data[7:0]}.
- `CLK`  in  1  system clock; all state changes on the rising edge.
- `RST`  in  1  reset, asynchronous, active-low.
- `START`  in  1  one-cycle pulse that begins a load session.
- `BYTE_IN`  in  8  host byte.
- `BYTE_VALID`  in  1  host byte valid.
- `BYTE_READY`  out  1  loader can accept a byte.
- `WR_EN`  out  1  instruction memory write strobe, one cycle per word.
- `WR_ADDR`  out  `AW`  instruction memory write address.
- `WR_DATA`  out  `IW`  instruction word, {opcode, data}.
- `CPU_RUN`  out  1  high means the core may execute; gates PC_EN/controller.
- `DONE`  out  1  image loaded successfully (level).
- `ERR`  out  1  session failed (level).

## Operation
- States:
  - IDLE: default state.
  - HDR: receives the header byte.
  - OPC: receives the opcode byte of a word.
  - DAT: receives the data byte of a word.
  - CHK: receives the checksum byte (only present with the macro).
  - RUN: image accepted; core running.
  - FAIL: session rejected.
- A byte is accepted on a rising edge with BYTE_VALID & BYTE_READY.
- BYTE_READY = 1 only in HDR, OPC, DAT and CHK. It is 0 in the cycle a WR_EN is issued.
- Transitions:
  - IDLE --START--> HDR.
  - HDR: header byte = word count N.
    - N = 0 or N > DEPTH → FAIL.
    - Otherwise latch N, clear the index and the running sum, → OPC.
  - OPC: latch BYTE_IN[3:0] as the opcode; upper nibble is ignored. → DAT.
  - DAT: latch the data byte. Next cycle: WR_EN=1, WR_ADDR=index, WR_DATA={opcode,data}; index increments.
    - If index+1 == N: → CHK with the macro, → RUN without it.
    - Otherwise → OPC.
  - CHK: running 8-bit sum (mod 256) of the header, all payload bytes and the checksum byte.
    - Sum == 0x00 → RUN.
    - Otherwise → FAIL.
  - RUN: CPU_RUN=1, DONE=1. START → HDR with CPU_RUN and DONE cleared.
  - FAIL: ERR=1, CPU_RUN=0. START → HDR with ERR cleared.
- START outside IDLE/RUN/FAIL is ignored.
- Words at addresses ≥ N are not written and keep their previous contents.
- The index is `AW`+1 bits wide so N = DEPTH does not wrap. WR_ADDR is its low `AW` bits.

## Timing
- Reset values: BYTE_READY=0, WR_EN=0, WR_ADDR=0, WR_DATA=0, CPU_RUN=0, DONE=0, ERR=0. Reset state is IDLE.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Write latency: WR_EN asserts exactly 1 cycle after the data byte is accepted, for 1 cycle.
- Maximum throughput is 3 cycles per word: opcode, data, write.
- CPU_RUN rises 1 cycle after the final accept: the last DAT byte without the macro, or the CHK byte with it. It never precedes the final WR_EN.
- A host stall (BYTE_VALID low) holds state indefinitely; there is no timeout.
- RST low at any point returns to IDLE asynchronously and drops CPU_RUN immediately. A partial image is not rolled back.
- When START and BYTE_VALID are both high in IDLE, START is taken and the byte is not accepted (BYTE_READY=0 in IDLE).

## Configuration
- `ROM_LOADER_CHECKSUM_EN` defined:
  - The CHK state and the running-sum register exist.
  - A trailing checksum byte is required.
  - A mismatch → FAIL with CPU_RUN held 0.
- Not defined:
  - No CHK state and no sum logic.
  - RUN is entered directly after the final write.
  - ERR asserts only for a bad header.

## Test plan
- Header 0x02, bytes 0x05,0xA1,0x0C,0x3F (plus checksum 0x0D if the macro is defined) → WR_EN at addr 0 with 0x5A1, addr 1 with 0xC3F; CPU_RUN=1, DONE=1.
- Header 0x00, and separately 0x21 → ERR=1, no WR_EN, CPU_RUN=0; START clears ERR and enters HDR.
- Macro on: header 0x01, bytes 0x01,0x10, checksum 0x00 (sum 0x12) → FAIL, ERR=1, CPU_RUN=0. Same stream with checksum 0xEE → RUN.
- Header 0x20 (DEPTH=32), 64 payload bytes with random BYTE_VALID gaps → 32 writes at addresses 0..31 in order, no address wrap, CPU_RUN after the last write.
- RST low mid-DAT after 3 words → all outputs 0 immediately, state IDLE; memory addresses 0..2 retain the written words.
- In RUN, a START pulse → CPU_RUN and DONE drop on the next edge, BYTE_READY=1, new header accepted.
